// File: rtl/program_loader_if.sv
// Bus bundle between the core front end and the program loader.
// Master side drives mode, UART receive bytes, PC and transmitter busy.
// Slave side (the loader) returns ACK bytes, fetched instructions and load status.
interface program_loader_if #(
  parameter int INST_SIZE = 15
);
  logic [1:0]         mode;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic [31:0]        pc;
  logic               tx_busy;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic [31:0]        inst;
  logic               load_done;
  logic [INST_SIZE:0] load_count;

  modport master (
    output mode, rx_data, rx_ready, pc, tx_busy,
    input  tx_data, tx_start, inst, load_done, load_count
  );

  modport slave (
    input  mode, rx_data, rx_ready, pc, tx_busy,
    output tx_data, tx_start, inst, load_done, load_count
  );
endinterface

// File: rtl/program_loader.sv
// Instruction-side front end: loads a length-prefixed big-endian program from the UART into BRAM, then serves fetches.
// Latency: fetch is one cycle (inst valid the cycle after pc); completed load word lands in BRAM one cycle after its 4th byte.
// Backpressure: rx bytes cannot be stalled (strobes outside HDR/BODY are dropped); the ACK byte waits for tx_busy low.
module program_loader #(
  parameter int         INST_SIZE = 15,
  parameter logic [7:0] ACK_BYTE  = 8'hAA
) (
  input  logic            clk,
  input  logic            rstn,
  program_loader_if.slave bus
);

  localparam int DEPTH = 2 ** INST_SIZE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Mode decode; encoding 3 behaves exactly like STALL.
  logic mode_load, mode_exec, mode_stall;
  assign mode_load  = (bus.mode == 2'd1);
  assign mode_exec  = (bus.mode == 2'd2);
  assign mode_stall = !mode_load && !mode_exec;

  // Byte assembly state. Only the low 3 bytes of the shift registers are kept:
  // the 4th byte is combined straight from rx_data when the word completes.
  logic [1:0]  byte_cnt;
  logic [23:0] hdr_sr;
  logic [23:0] word_sr;
  logic [31:0] n_words;
  logic [31:0] word_addr;
  logic [31:0] hdr_full;
  logic [31:0] word_full;
  logic        in_range;
  logic        last_word;

  assign hdr_full  = {hdr_sr, bus.rx_data};
  assign word_full = {word_sr, bus.rx_data};
  assign in_range  = ((word_addr >> INST_SIZE) == 32'd0);
  assign last_word = ((word_addr + 32'd1) == n_words);

  // Registered outputs and the pending BRAM write.
  logic [7:0]           tx_data_q;
  logic                 tx_start_q;
  logic [31:0]          inst_q;
  logic                 load_done_q;
  logic [INST_SIZE:0]   load_count_q;
  logic                 wr_pend;
  logic [INST_SIZE-1:0] wr_addr;
  logic [31:0]          wr_dat;

  logic [31:0] mem [DEPTH];

  // Control strobes from the output decode.
  logic clr_load;
  logic hdr_byte;
  logic body_byte;
  logic word_done;
  logic fire_ack;
  logic clr_done;

  // Upper PC bits are ignored: fetch addresses wrap modulo DEPTH.
  logic unused_pc_hi;
  assign unused_pc_hi = ^bus.pc[31:INST_SIZE];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; STALL aborts any load still in progress.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (mode_load) state_nxt = HDR;
      end
      HDR: begin
        if (mode_stall) begin
          state_nxt = IDLE;
        end else if (bus.rx_ready && byte_cnt == 2'd3) begin
          state_nxt = (hdr_full == 32'd0) ? ACK : BODY;
        end
      end
      BODY: begin
        if (mode_stall) begin
          state_nxt = IDLE;
        end else if (bus.rx_ready && byte_cnt == 2'd3 && last_word) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (mode_stall) begin
          state_nxt = IDLE;
        end else if (!bus.tx_busy) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (mode_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: per-state datapath strobes.
  always_comb begin
    clr_load  = 1'b0;
    hdr_byte  = 1'b0;
    body_byte = 1'b0;
    word_done = 1'b0;
    fire_ack  = 1'b0;
    clr_done  = 1'b0;
    unique case (state)
      IDLE: clr_load = mode_load;
      HDR:  hdr_byte = !mode_stall && bus.rx_ready;
      BODY: begin
        body_byte = !mode_stall && bus.rx_ready;
        word_done = !mode_stall && bus.rx_ready && (byte_cnt == 2'd3);
      end
      ACK:  fire_ack = !mode_stall && !bus.tx_busy;
      default: ;
    endcase
    if (state != IDLE && state_nxt == IDLE) clr_done = 1'b1;
  end

  // Load datapath: byte assembly, word addressing, ACK and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt     <= 2'd0;
      hdr_sr       <= 24'd0;
      word_sr      <= 24'd0;
      n_words      <= 32'd0;
      word_addr    <= 32'd0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      wr_pend      <= 1'b0;
      wr_addr      <= '0;
      wr_dat       <= 32'd0;
    end else begin
      tx_start_q <= 1'b0;
      wr_pend    <= 1'b0;

      if (clr_load) begin
        byte_cnt     <= 2'd0;
        word_addr    <= 32'd0;
        load_count_q <= '0;
      end

      if (hdr_byte) begin
        hdr_sr   <= hdr_full[23:0];
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) n_words <= hdr_full;
      end

      if (body_byte) begin
        word_sr  <= word_full[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Words past the end of memory are consumed but never written.
      if (word_done) begin
        word_addr <= word_addr + 32'd1;
        if (in_range) begin
          wr_pend      <= 1'b1;
          wr_addr      <= word_addr[INST_SIZE-1:0];
          wr_dat       <= word_full;
          load_count_q <= load_count_q + {{INST_SIZE{1'b0}}, 1'b1};
        end
      end

      if (fire_ack) begin
        tx_start_q  <= 1'b1;
        tx_data_q   <= ACK_BYTE;
        load_done_q <= 1'b1;
      end

      if (clr_done) load_done_q <= 1'b0;
    end
  end

  // BRAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_pend) mem[wr_addr] <= wr_dat;
  end

  // Fetch: registered read while in EXEC; a late pending write owns the shared port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_q <= 32'd0;
    end else if (mode_exec && !wr_pend) begin
      inst_q <= mem[bus.pc[INST_SIZE-1:0]];
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.inst       = inst_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: one default-size instance and one with a 4-word memory.
// Stimulus pushes expected ACK bytes and fetch words into queues; a monitor pops and compares on tx_start / fetch return.
module tb_program_loader;

  logic clk;
  logic rstn;

  program_loader_if #(.INST_SIZE(15)) ifa ();
  program_loader_if #(.INST_SIZE(2))  ifb ();

  program_loader #(.INST_SIZE(15), .ACK_BYTE(8'hAA)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa.slave)
  );

  program_loader #(.INST_SIZE(2), .ACK_BYTE(8'hAA)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_tx [$];   // {dut id, byte}
  logic [32:0] exp_rd [$];   // {dut id, word}

  logic rd_req = 1'b0;
  logic rd_id  = 1'b0;
  logic rd_pend = 1'b0;
  logic rd_pend_id = 1'b0;
  logic busy_q_a = 1'b0;
  logic busy_q_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tx_observe(input logic id, input logic [7:0] d, input logic busy_before);
    logic [8:0] e;
    checks++;
    if (exp_tx.size() == 0) begin
      errors++;
      $display("FAIL tx_unexpected dut%0d got 0x%02h expected no pulse", id, d);
    end else begin
      e = exp_tx.pop_front();
      if (e !== {id, d}) begin
        errors++;
        $display("FAIL tx_byte got dut%0d 0x%02h expected dut%0d 0x%02h", id, d, e[8], e[7:0]);
      end
    end
    checks++;
    if (busy_before) begin
      errors++;
      $display("FAIL tx_while_busy dut%0d got tx_busy=1 expected 0", id);
    end
  endtask

  task automatic rd_observe(input logic id, input logic [31:0] w);
    logic [32:0] e;
    checks++;
    if (exp_rd.size() == 0) begin
      errors++;
      $display("FAIL rd_unexpected dut%0d got 0x%08h expected none", id, w);
    end else begin
      e = exp_rd.pop_front();
      if (e !== {id, w}) begin
        errors++;
        $display("FAIL fetch got dut%0d 0x%08h expected dut%0d 0x%08h", id, w, e[32], e[31:0]);
      end
    end
  endtask

  // Monitor: capture pre-edge conditions on the rising edge, compare on the falling edge.
  always @(posedge clk) begin
    rd_pend    <= rd_req;
    rd_pend_id <= rd_id;
    busy_q_a   <= ifa.tx_busy;
    busy_q_b   <= ifb.tx_busy;
  end

  always @(negedge clk) begin
    if (ifa.tx_start) tx_observe(1'b0, ifa.tx_data, busy_q_a);
    if (ifb.tx_start) tx_observe(1'b1, ifb.tx_data, busy_q_b);
    if (rd_pend) rd_observe(rd_pend_id, rd_pend_id ? ifb.inst : ifa.inst);
  end

  // All drive tasks start and end on a falling edge.
  task automatic set_mode(input logic id, input logic [1:0] m);
    if (id) ifb.mode = m; else ifa.mode = m;
  endtask

  task automatic send_byte(input logic id, input logic [7:0] b);
    if (id) begin ifb.rx_data = b; ifb.rx_ready = 1'b1; end
    else    begin ifa.rx_data = b; ifa.rx_ready = 1'b1; end
    @(negedge clk);
    ifa.rx_ready = 1'b0;
    ifb.rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic id, input logic [31:0] w);
    send_byte(id, w[31:24]);
    send_byte(id, w[23:16]);
    send_byte(id, w[15:8]);
    send_byte(id, w[7:0]);
  endtask

  task automatic start_load(input logic id);
    set_mode(id, 2'd0);
    @(negedge clk);
    set_mode(id, 2'd1);
    @(negedge clk);
  endtask

  task automatic fetch(input logic id, input logic [31:0] addr, input logic [31:0] exp);
    if (id) ifb.pc = addr; else ifa.pc = addr;
    exp_rd.push_back({id, exp});
    rd_id  = id;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int viol;

    rstn = 1'b0;
    ifa.mode = 2'd0; ifa.rx_data = 8'd0; ifa.rx_ready = 1'b0; ifa.pc = 32'd0; ifa.tx_busy = 1'b0;
    ifb.mode = 2'd0; ifb.rx_data = 8'd0; ifb.rx_ready = 1'b0; ifb.pc = 32'd0; ifb.tx_busy = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_inst",       ifa.inst, 32'd0);
    check("rst_load_done",  {31'd0, ifa.load_done}, 32'd0);
    check("rst_load_count", {16'd0, ifa.load_count}, 32'd0);
    check("rst_tx_start",   {31'd0, ifa.tx_start}, 32'd0);
    check("rst_tx_data",    {24'd0, ifa.tx_data}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Two-word load, then fetch.
    start_load(1'b0);
    send_word(1'b0, 32'd2);
    send_word(1'b0, 32'hDEADBEEF);
    exp_tx.push_back({1'b0, 8'hAA});
    send_word(1'b0, 32'h01234567);
    repeat (4) @(negedge clk);
    check("t1_load_count", {16'd0, ifa.load_count}, 32'd2);
    check("t1_load_done",  {31'd0, ifa.load_done}, 32'd1);
    set_mode(1'b0, 2'd2);
    fetch(1'b0, 32'd0, 32'hDEADBEEF);
    fetch(1'b0, 32'd1, 32'h01234567);
    fetch(1'b0, 32'h0001_8001, 32'h01234567);
    fetch(1'b0, 32'h0000_8000, 32'hDEADBEEF);
    @(negedge clk);
    set_mode(1'b0, 2'd0);
    @(negedge clk);
    check("t1_done_clr_stall", {31'd0, ifa.load_done}, 32'd0);

    // Empty program.
    start_load(1'b0);
    exp_tx.push_back({1'b0, 8'hAA});
    send_word(1'b0, 32'd0);
    n = 0;
    while (!ifa.load_done && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("t2_done_within3", {31'd0, ifa.load_done}, 32'd1);
    check("t2_load_count",   {16'd0, ifa.load_count}, 32'd0);
    repeat (2) @(negedge clk);
    set_mode(1'b0, 2'd2);
    fetch(1'b0, 32'd0, 32'hDEADBEEF);
    fetch(1'b0, 32'd1, 32'h01234567);
    @(negedge clk);

    // ACK held off by a busy transmitter.
    start_load(1'b0);
    ifa.tx_busy = 1'b1;
    send_word(1'b0, 32'd1);
    send_word(1'b0, 32'h11223344);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (ifa.tx_start) viol++;
    end
    check("t3_no_tx_while_busy", viol, 32'd0);
    check("t3_not_done_busy",    {31'd0, ifa.load_done}, 32'd0);
    exp_tx.push_back({1'b0, 8'hAA});
    ifa.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_done", {31'd0, ifa.load_done}, 32'd1);
    set_mode(1'b0, 2'd2);
    fetch(1'b0, 32'd0, 32'h11223344);
    @(negedge clk);

    // Abort mid-body, then reload one word.
    start_load(1'b0);
    send_word(1'b0, 32'd3);
    send_word(1'b0, 32'hAABBCCDD);
    send_byte(1'b0, 8'hEE);
    set_mode(1'b0, 2'd0);
    repeat (2) @(negedge clk);
    check("t4_abort_done", {31'd0, ifa.load_done}, 32'd0);
    set_mode(1'b0, 2'd2);
    fetch(1'b0, 32'd0, 32'hAABBCCDD);
    fetch(1'b0, 32'd1, 32'h01234567);
    @(negedge clk);
    start_load(1'b0);
    send_word(1'b0, 32'd1);
    exp_tx.push_back({1'b0, 8'hAA});
    send_word(1'b0, 32'hCAFEF00D);
    repeat (4) @(negedge clk);
    check("t4_reload_done",  {31'd0, ifa.load_done}, 32'd1);
    check("t4_reload_count", {16'd0, ifa.load_count}, 32'd1);
    set_mode(1'b0, 2'd2);
    fetch(1'b0, 32'd0, 32'hCAFEF00D);
    fetch(1'b0, 32'd1, 32'h01234567);
    @(negedge clk);

    // Asynchronous reset mid-body.
    start_load(1'b0);
    send_word(1'b0, 32'd2);
    send_word(1'b0, 32'h55667788);
    send_byte(1'b0, 8'h99);
    send_byte(1'b0, 8'h77);
    check("t5_count_before_rst", {16'd0, ifa.load_count}, 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    check("t5_rst_inst",       ifa.inst, 32'd0);
    check("t5_rst_load_count", {16'd0, ifa.load_count}, 32'd0);
    check("t5_rst_tx_data",    {24'd0, ifa.tx_data}, 32'd0);
    check("t5_rst_load_done",  {31'd0, ifa.load_done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    set_mode(1'b0, 2'd2);
    @(negedge clk);
    send_word(1'b0, 32'd1);
    send_word(1'b0, 32'h0BADC0DE);
    check("t5_exec_rx_count", {16'd0, ifa.load_count}, 32'd0);
    check("t5_exec_rx_done",  {31'd0, ifa.load_done}, 32'd0);
    fetch(1'b0, 32'd0, 32'h55667788);
    fetch(1'b0, 32'd1, 32'h01234567);
    @(negedge clk);

    // Overflowing load into a 4-word memory.
    start_load(1'b1);
    send_word(1'b1, 32'd6);
    for (int w = 1; w <= 6; w++) begin
      if (w == 6) exp_tx.push_back({1'b1, 8'hAA});
      send_word(1'b1, w);
    end
    repeat (4) @(negedge clk);
    check("t6_load_count", {29'd0, ifb.load_count}, 32'd4);
    check("t6_load_done",  {31'd0, ifb.load_done}, 32'd1);
    set_mode(1'b1, 2'd2);
    fetch(1'b1, 32'd0, 32'd1);
    fetch(1'b1, 32'd1, 32'd2);
    fetch(1'b1, 32'd2, 32'd3);
    fetch(1'b1, 32'd3, 32'd4);
    fetch(1'b1, 32'd5, 32'd2);
    fetch(1'b1, 32'd7, 32'd4);
    repeat (3) @(negedge clk);

    check("tx_queue_drained", exp_tx.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
